uart_data_regfile: RTL
======================

Name: uart_data_regfile

Overview:
Parametrised dual-write, single-read register file for the UART data path, holding received and transmit words. Both write ports commit in the same cycle when their addresses differ. When both ports hit the same address, bytes are merged with port 1 taking priority. The read port is registered with one-cycle latency, write-first bypass and a hold function. It also provides per-entry valid flags, a collision pulse and a saturating write counter for debug.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
CNT_W, 16, width of the saturating write counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
wr1_en  in  1  write strobe, port 1 (priority port).
wr1_addr  in  ADDR_W  write address, port 1.
wr1_data  in  DATA_W  write data, port 1.
wr1_be  in  DATA_W/8  byte enables, port 1.
wr2_en  in  1  write strobe, port 2.
wr2_addr  in  ADDR_W  write address, port 2.
wr2_data  in  DATA_W  write data, port 2.
wr2_be  in  DATA_W/8  byte enables, port 2.
rd_en  in  1  read request.
rd_addr  in  ADDR_W  read address.
hold  in  1  freeze read outputs.
rd_data  out  DATA_W  registered read data.
rd_valid  out  1  rd_data updated this cycle.
rd_entry_valid  out  1  addressed entry has been written since reset.
collision  out  1  one-cycle pulse: both ports wrote overlapping bytes of one address.
wr_count  out  CNT_W  saturating count of committed write cycles.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All entries are set to 0 and all entry-valid bits cleared.
  - rd_data=0, rd_valid=0, rd_entry_valid=0, collision=0, wr_count=0.
  - All requests in the reset cycle are ignored, including writes.
- Writes take effect at the clk edge. Byte i of an entry updates only if the corresponding be[i]=1. An enable with be=0 writes nothing and does not set the valid bit.
- Different addresses: both ports commit independently in the same cycle.
- Same address, both enabled:
  - Bytes enabled on port 1 take port 1 data.
  - Bytes enabled only on port 2 take port 2 data.
  - collision=1 in the next cycle if (wr1_be & wr2_be) != 0; otherwise collision=0.
- Entry-valid bit for an address is set when any byte of it is written.
- wr_count increments by 1 per cycle in which at least one port writes at least one byte. Two ports writing in one cycle still count as 1. The counter saturates at 2**CNT_W-1 and does not wrap.
- Read, 1-cycle latency: rd_en at edge N gives rd_data/rd_valid/rd_entry_valid at edge N+1, with rd_valid high for exactly one cycle per accepted read.
- Write-first bypass: a read of an address written in the same cycle returns the post-write merged word and the updated valid bit.
- hold=1:
  - rd_data and rd_entry_valid keep their values, rd_valid=0, and the read request is dropped, not queued.
  - Writes, collision and wr_count are unaffected by hold.
- rd_en=0: rd_data holds its last value and rd_valid=0.
- Reset has priority over all other inputs. Reset mid-sequence discards any in-flight read: rd_valid=0 in the following cycle.
- No combinational path from inputs to outputs; every output is driven from a register.

Test Plan:
- Reset then rd_en at addr 3 -> after 1 cycle: rd_data=0, rd_valid=1, rd_entry_valid=0; wr_count=0.
- wr1 addr 2 data 0xAABBCCDD be=0xF, together with wr2 addr 5 data 0x11223344 be=0xF; next cycle read 2, then read 5 -> 0xAABBCCDD, then 0x11223344, each with rd_entry_valid=1; wr_count=1.
- Same address 7: wr1 data 0xAAAAAAAA be=0x3, wr2 data 0xBBBBBBBB be=0x6 -> entry = 0x00BBAAAA; collision=1 for one cycle. Repeat with wr2 be=0xC -> entry = 0xBBBBAAAA; collision=0.
- wr1 addr 4 data 0x12345678 with rd_en addr 4 in the same cycle -> rd_data=0x12345678 next cycle (bypass).
- Load addr 1 with 0x55; read addr 1; raise hold and issue rd_en addr 2 (holding 0x66) -> rd_data stays 0x55 and rd_valid=0 for every held cycle. Lower hold and re-read addr 2 -> 0x66.
- With CNT_W=2, perform 5 write cycles -> wr_count sequence 1,2,3,3,3. Then assert rst during a read -> rd_valid=0 and all entries read back as 0.

Source files
------------

// File: rtl/uart_data_regfile.sv
// UART data-path register file: two byte-enabled write ports (port 1 wins on overlap),
// one registered read port with write-first bypass and hold, plus debug status outputs.
module uart_data_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic [DATA_W/8-1:0]   wr1_be,
  input  logic                  wr2_en,
  input  logic [ADDR_W-1:0]     wr2_addr,
  input  logic [DATA_W-1:0]     wr2_data,
  input  logic [DATA_W/8-1:0]   wr2_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  hold,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_entry_valid,
  output logic                  collision,
  output logic [CNT_W-1:0]      wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] mem_next [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  valid_next;
  logic              wr1_any;
  logic              wr2_any;
  logic              coll_next;

  assign wr1_any   = wr1_en & (|wr1_be);
  assign wr2_any   = wr2_en & (|wr2_be);
  assign coll_next = wr1_en & wr2_en & (wr1_addr == wr2_addr) & (|(wr1_be & wr2_be));

  // Post-write image of the array; port 1 is applied last so it overrides port 2
  // on shared bytes, and the read port samples this image for write-first bypass.
  always_comb begin
    mem_next   = mem;
    valid_next = valid;
    if (wr2_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr2_be[i]) mem_next[wr2_addr][i*8 +: 8] = wr2_data[i*8 +: 8];
      end
    end
    if (wr1_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr1_be[i]) mem_next[wr1_addr][i*8 +: 8] = wr1_data[i*8 +: 8];
      end
    end
    if (wr2_any) valid_next[wr2_addr] = 1'b1;
    if (wr1_any) valid_next[wr1_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem       <= '{default: '0};
      valid     <= '0;
      collision <= 1'b0;
      wr_count  <= '0;
    end else begin
      mem       <= mem_next;
      valid     <= valid_next;
      collision <= coll_next;
      if ((wr1_any || wr2_any) && (wr_count != '1)) wr_count <= wr_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      rd_entry_valid <= 1'b0;
    end else if (hold || !rd_en) begin
      rd_valid <= 1'b0;
    end else begin
      rd_data        <= mem_next[rd_addr];
      rd_entry_valid <= valid_next[rd_addr];
      rd_valid       <= 1'b1;
    end
  end

endmodule
